// File: rtl/prog_mode_lut.sv
// prog_mode_lut: programmable per-mode membership table with a two-stage
// valid/ready lookup pipeline and a saturating counter of delivered hits.
module prog_mode_lut #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned MODES  = 8,
  parameter int unsigned MODE_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [MODE_W-1:0]        wr_mode,
  input  logic [(2**ADDR_W)-1:0]   wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [MODE_W-1:0]        in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_hit,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         hit_cnt
);

  localparam int unsigned ROW_W = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ROW_W-1:0]  w_rows [MODES];
  logic [ROW_W-1:0]  w_row;
  logic              w_lookup;
  logic              w_adv;

  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [MODE_W-1:0] r_s1_mode;
  logic              r_s2_valid;
  logic              r_s2_hit;
  logic [CNT_W-1:0]  r_hit_cnt;

  // One register row per mode; out-of-range write indices match no row.
  for (genvar g = 0; g < MODES; g++) begin : g_row
    logic [ROW_W-1:0] r_row;

    // Row storage: cleared on reset, loaded on a matching write strobe.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_row <= '0;
      end else if (wr_en && (wr_mode == MODE_W'(g))) begin
        r_row <= wr_data;
      end
    end

    assign w_rows[g] = r_row;
  end

  // Row select for the S1 request; modes beyond the table read as all zeros.
  always_comb begin
    w_row = '0;
    for (int m = 0; m < MODES; m++) begin
      if (r_s1_mode == MODE_W'(m)) begin
        w_row = w_rows[m];
      end
    end
  end

  assign w_lookup  = w_row[r_s1_addr];
  assign w_adv     = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_adv;
  assign out_valid = r_s2_valid;
  assign out_hit   = r_s2_hit;
  assign hit_cnt   = r_hit_cnt;

  // Stage 1: capture the request whenever the stage can accept a new one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_mode  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_addr <= in_addr;
        r_s1_mode <= in_mode;
      end
    end
  end

  // Stage 2: register the table bit on transfer; holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_hit   <= r_s1_valid & w_lookup;
    end
  end

  // Delivered-hit counter: clear wins over increment, saturates at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (r_s2_valid && out_ready && r_s2_hit && (r_hit_cnt != CNT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/prog_mode_lut.md
PROG_MODE_LUT -- requirements
Module: prog_mode_lut

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, lookup address width; table row width is 2**ADDR_W bits.
REQ-002 SHALL have parameter MODES, default 8, number of selectable modes (table rows).
REQ-003 SHALL have parameter MODE_W, default 3, mode/select field width; MODES <= 2**MODE_W.
REQ-004 SHALL have parameter CNT_W, default 16, hit counter width.
REQ-005 SHALL have ports, name / direction / width / meaning:
 clk  in  1  single clock, all state updates on rising edge.
 rst_n  in  1  reset, synchronous, active-low.
 wr_en  in  1  table row write strobe.
 wr_mode  in  MODE_W  row index to write.
 wr_data  in  2**ADDR_W  row contents; bit k = member flag for address k.
 in_valid  in  1  lookup request valid.
 in_ready  out  1  lookup request accepted when in_valid & in_ready.
 in_addr  in  ADDR_W  lookup address.
 in_mode  in  MODE_W  lookup mode.
 out_valid  out  1  result valid.
 out_ready  in  1  downstream accepts when out_valid & out_ready.
 out_hit  out  1  table[mode][addr] result.
 cnt_clr  in  1  clear hit counter.
 hit_cnt  out  CNT_W  count of delivered hits.

Function
REQ-006 SHALL hold a MODES x 2**ADDR_W bit register table.
REQ-007 SHALL write wr_data into row wr_mode on the edge where wr_en=1; wr_mode >= MODES SHALL be ignored.
REQ-008 SHALL implement a 2-stage lookup pipeline: S1 captures {in_addr,in_mode}; S2 registers out_hit.
REQ-009 Latency: accepted request SHALL present out_valid exactly 2 cycles after acceptance edge when out_ready held 1.
REQ-010 Pipeline advance: adv = ~s2_valid | out_ready; S1->S2 transfer when s1_valid & adv.
REQ-011 in_ready SHALL equal ~s1_valid | adv (combinational); full throughput 1 lookup/cycle when out_ready=1.
REQ-012 out_valid, out_hit SHALL stay stable while out_valid=1 & out_ready=0 (no drop, no duplication).
REQ-013 out_hit SHALL be table bit read at the S1->S2 transfer edge; a same-edge write to that row SHALL NOT affect it (old value).
REQ-014 Lookup with mode >= MODES SHALL return out_hit=0.
REQ-015 hit_cnt SHALL increment by 1 on each edge with out_valid & out_ready & out_hit; saturate at 2**CNT_W-1.
REQ-016 cnt_clr=1 SHALL set hit_cnt=0 next edge, priority over increment.
REQ-017 Writes SHALL be accepted every cycle independent of pipeline stall state.

Reset
REQ-018 On edge with rst_n=0: table all zeros, s1_valid=0, s2_valid=0, out_valid=0, out_hit=0, hit_cnt=0.
REQ-019 in_ready SHALL read 1 in the cycle following reset deassertion.
REQ-020 Reset mid-operation SHALL discard in-flight lookups; no out_valid until a new request is accepted.

Verification
REQ-021 Write row 3 = 0x0000_00F0, lookup mode 3 addr 4, out_ready=1 -> out_valid 2 cycles later, out_hit=1, hit_cnt=1.
REQ-022 Back-to-back lookups mode 3 addr 0..7 with out_ready=1 -> 8 consecutive results 0,0,0,0,1,1,1,1, in_ready never 0, hit_cnt=4.
REQ-023 out_ready=0 for 5 cycles with stream in_valid=1 -> in_ready falls after 2 accepts, out_hit held; release -> all results in order, none lost.
REQ-024 Write row 3 = 0 on same edge as S1->S2 transfer of mode 3 addr 4 -> out_hit=1; next lookup -> 0.
REQ-025 Lookup mode 7 with MODES=6 -> out_hit=0; CNT_W=2 with 5 hits -> hit_cnt=3; cnt_clr with hit -> hit_cnt=0.
REQ-026 rst_n=0 with both stages full -> next cycle out_valid=0, hit_cnt=0, all table lookups return 0.
